// File: rtl/window_load_controller_pkg.sv
// Shared constants, state encoding and sizing helper for the window load controller.
package window_load_controller_pkg;

  localparam int unsigned CAMERA_PIXEL_BITWIDTH = 8;
  localparam int unsigned DEF_BUFFER_W          = 28;
  localparam int unsigned DEF_BUFFER_H          = 28;
  localparam int unsigned DEF_PIXEL_W           = CAMERA_PIXEL_BITWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } wlc_state_e;

  // Counter width for a range of n values; at least one bit even for n < 2.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_load_controller_raster_counter.sv
// Column/row raster counter with wrap and end-of-row / end-of-frame flags.
module window_load_controller_raster_counter
  import window_load_controller_pkg::*;
#(
  parameter int unsigned BUFFER_W = DEF_BUFFER_W,
  parameter int unsigned BUFFER_H = DEF_BUFFER_H,
  parameter int unsigned COL_W    = cnt_w(BUFFER_W),
  parameter int unsigned ROW_W    = cnt_w(BUFFER_H)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col_idx,
  output logic [ROW_W-1:0] row_idx,
  output logic             end_of_row,
  output logic             last_row,
  output logic             end_of_frame
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BUFFER_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BUFFER_H - 1);

  // Position flags decoded from the current counter values.
  always_comb begin
    end_of_row   = (col_idx == COL_LAST);
    last_row     = (row_idx == ROW_LAST);
    end_of_frame = end_of_row && last_row;
  end

  // Raster advance: column wraps into the next row, row wraps at end of frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_idx <= '0;
      row_idx <= '0;
    end else if (clear) begin
      col_idx <= '0;
      row_idx <= '0;
    end else if (advance) begin
      if (end_of_row) begin
        col_idx <= '0;
        row_idx <= last_row ? '0 : row_idx + ROW_W'(1);
      end else begin
        col_idx <= col_idx + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/window_load_controller.sv
// Sequences loading of the image shifting window from a valid/ready pixel stream
// and holds the loaded frame until the convolution engine releases it.
module window_load_controller
  import window_load_controller_pkg::*;
#(
  parameter int unsigned BUFFER_W = DEF_BUFFER_W,
  parameter int unsigned BUFFER_H = DEF_BUFFER_H,
  parameter int unsigned PIXEL_W  = DEF_PIXEL_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [PIXEL_W-1:0]          pixel_in,
  input  logic                        pixel_valid,
  output logic                        pixel_ready,
  input  logic                        conv_done,
  output logic [PIXEL_W-1:0]          win_pixel,
  output logic                        shift_left,
  output logic                        shift_up,
  output logic                        buffer_full,
  output logic [cnt_w(BUFFER_W)-1:0]  col_idx,
  output logic [cnt_w(BUFFER_H)-1:0]  row_idx
);

  wlc_state_e state;
  logic       accept;
  logic       clear_cnt;
  logic       up_pending;
  logic       end_of_row;
  logic       last_row;
  logic       end_of_frame;

  // Handshake and counter-clear decode from the current state.
  always_comb begin
    pixel_ready = (state == LOAD);
    accept      = pixel_valid && pixel_ready;
    clear_cnt   = (state == IDLE) && start;
  end

  window_load_controller_raster_counter #(
    .BUFFER_W (BUFFER_W),
    .BUFFER_H (BUFFER_H)
  ) u_raster (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear_cnt),
    .advance      (accept),
    .col_idx      (col_idx),
    .row_idx      (row_idx),
    .end_of_row   (end_of_row),
    .last_row     (last_row),
    .end_of_frame (end_of_frame)
  );

  // FSM plus registered strobes; shift_up trails the row-ending shift_left by one
  // cycle via up_pending so row 0 is complete before the rows move up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      win_pixel   <= '0;
      shift_left  <= 1'b0;
      shift_up    <= 1'b0;
      up_pending  <= 1'b0;
      buffer_full <= 1'b0;
    end else begin
      shift_left  <= accept;
      shift_up    <= up_pending;
      up_pending  <= accept && end_of_row && !last_row;
      buffer_full <= (state == FULL) && !conv_done;
      if (accept) begin
        win_pixel <= pixel_in;
      end
      case (state)
        IDLE:    if (start) state <= LOAD;
        LOAD:    if (accept && end_of_frame) state <= FULL;
        FULL:    if (conv_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_load_controller.sv
// Self-checking bench: a 3x2 and a default 28x28 controller, each with a cycle model
// and a pixel scoreboard popped whenever the DUT strobes shift_left.
module tb_window_load_controller;

  localparam int unsigned SW = 3;
  localparam int unsigned SH = 2;
  localparam int unsigned BW = 28;
  localparam int unsigned BH = 28;
  localparam int unsigned PW = 9;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sel   = 1'b1;

  logic          st_d = 1'b0;
  logic          pv_d = 1'b0;
  logic          cd_d = 1'b0;
  logic [PW-1:0] px_d = '0;

  logic          s_start, s_valid, s_cd, s_ready, s_sl, s_su, s_bf;
  logic [PW-1:0] s_win;
  logic [1:0]    s_col;
  logic          s_row;

  logic          b_start, b_valid, b_cd, b_ready, b_sl, b_su, b_bf;
  logic [PW-1:0] b_win;
  logic [4:0]    b_col;
  logic [4:0]    b_row;

  logic          o_ready, o_sl, o_su, o_bf;
  logic [PW-1:0] o_win;
  logic [4:0]    o_col, o_row;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_sl, n_su, n_acc;
  int su_sl_idx, last_acc_edge, first_bf_edge;

  int          m_state [2];
  int unsigned m_col   [2];
  int unsigned m_row   [2];
  logic        m_up    [2];
  logic [PW-1:0] sb [$];

  always #5 clock = ~clock;

  assign s_start = sel & st_d;
  assign s_valid = sel & pv_d;
  assign s_cd    = sel & cd_d;
  assign b_start = ~sel & st_d;
  assign b_valid = ~sel & pv_d;
  assign b_cd    = ~sel & cd_d;

  always_comb begin
    o_ready = sel ? s_ready : b_ready;
    o_sl    = sel ? s_sl    : b_sl;
    o_su    = sel ? s_su    : b_su;
    o_bf    = sel ? s_bf    : b_bf;
    o_win   = sel ? s_win   : b_win;
    o_col   = sel ? 5'(s_col) : b_col;
    o_row   = sel ? 5'(s_row) : b_row;
  end

  window_load_controller #(.BUFFER_W(SW), .BUFFER_H(SH), .PIXEL_W(PW)) dut_s (
    .clock(clock), .reset(reset), .start(s_start), .pixel_in(px_d),
    .pixel_valid(s_valid), .pixel_ready(s_ready), .conv_done(s_cd),
    .win_pixel(s_win), .shift_left(s_sl), .shift_up(s_su),
    .buffer_full(s_bf), .col_idx(s_col), .row_idx(s_row)
  );

  window_load_controller #(.BUFFER_W(BW), .BUFFER_H(BH), .PIXEL_W(PW)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .pixel_in(px_d),
    .pixel_valid(b_valid), .pixel_ready(b_ready), .conv_done(b_cd),
    .win_pixel(b_win), .shift_left(b_sl), .shift_up(b_su),
    .buffer_full(b_bf), .col_idx(b_col), .row_idx(b_row)
  );

  task automatic model_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_col[i]   = 0;
      m_row[i]   = 0;
      m_up[i]    = 1'b0;
    end
    sb.delete();
  endtask

  // Drives one cycle (entered at posedge+1), advances the model, pushes accepted
  // pixels to the scoreboard and pops/compares them as shift_left fires.
  task automatic drive_cycle(input logic v, input logic [PW-1:0] px,
                             input logic st, input logic cd);
    int s, w, h;
    logic acc, exp_su, exp_bf;
    logic [PW-1:0] exp_px;
    s = sel ? 1 : 0;
    w = sel ? SW : BW;
    h = sel ? SH : BH;
    pv_d = v; px_d = px; st_d = st; cd_d = cd;
    #1;
    checks++;
    if (o_ready !== (m_state[s] == 1)) begin
      errors++;
      $display("FAIL pixel_ready cyc %0d got %b exp %b", cyc, o_ready, (m_state[s] == 1));
    end
    checks++;
    if (o_col !== 5'(m_col[s]) || o_row !== 5'(m_row[s])) begin
      errors++;
      $display("FAIL idx cyc %0d got col %0d row %0d exp col %0d row %0d",
               cyc, o_col, o_row, m_col[s], m_row[s]);
    end
    acc = v && (m_state[s] == 1);
    if (acc) begin
      sb.push_back(px);
      n_acc++;
      last_acc_edge = cyc + 1;
    end
    exp_su = m_up[s];
    exp_bf = (m_state[s] == 2) && !cd;
    m_up[s] = acc && (m_col[s] == w - 1) && (m_row[s] < h - 1);
    case (m_state[s])
      0: if (st) begin m_state[s] = 1; m_col[s] = 0; m_row[s] = 0; end
      1: if (acc) begin
           if (m_col[s] == w - 1) begin
             m_col[s] = 0;
             if (m_row[s] == h - 1) begin m_row[s] = 0; m_state[s] = 2; end
             else m_row[s] = m_row[s] + 1;
           end else begin
             m_col[s] = m_col[s] + 1;
           end
         end
      default: if (cd) m_state[s] = 0;
    endcase
    @(posedge clock);
    #1;
    cyc++;
    pv_d = 1'b0; st_d = 1'b0; cd_d = 1'b0;
    checks++;
    if (o_sl !== acc) begin
      errors++;
      $display("FAIL shift_left cyc %0d got %b exp %b", cyc, o_sl, acc);
    end
    if (o_sl === 1'b1) begin
      n_sl++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard cyc %0d got win_pixel %0d exp no pending pixel", cyc, o_win);
      end else begin
        exp_px = sb.pop_front();
        if (o_win !== exp_px) begin
          errors++;
          $display("FAIL win_pixel cyc %0d got %0d exp %0d", cyc, o_win, exp_px);
        end
      end
    end
    checks++;
    if (o_su !== exp_su) begin
      errors++;
      $display("FAIL shift_up cyc %0d got %b exp %b", cyc, o_su, exp_su);
    end
    if (o_su === 1'b1) begin
      n_su++;
      if (o_sl === 1'b1) su_sl_idx = n_sl;
    end
    checks++;
    if (o_bf !== exp_bf) begin
      errors++;
      $display("FAIL buffer_full cyc %0d got %b exp %b", cyc, o_bf, exp_bf);
    end
    if (o_bf === 1'b1 && first_bf_edge < 0) first_bf_edge = cyc;
  endtask

  task automatic clear_stats();
    n_sl = 0; n_su = 0; n_acc = 0;
    su_sl_idx = -1; last_acc_edge = -1; first_bf_edge = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({s_ready, s_sl, s_su, s_bf, s_win, s_col, s_row} !== '0) begin
      errors++;
      $display("FAIL reset_small got %b exp 0", {s_ready, s_sl, s_su, s_bf, s_win, s_col, s_row});
    end
    checks++;
    if ({b_ready, b_sl, b_su, b_bf, b_win, b_col, b_row} !== '0) begin
      errors++;
      $display("FAIL reset_big got %b exp 0", {b_ready, b_sl, b_su, b_bf, b_win, b_col, b_row});
    end
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
  endtask

  task automatic test_small_frame();
    sel = 1'b1;
    clear_stats();
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int unsigned i = 1; i <= 6; i++) drive_cycle(1'b1, PW'(i), 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (n_sl != 6 || n_su != 1) begin
      errors++;
      $display("FAIL small_totals got sl %0d su %0d exp sl 6 su 1", n_sl, n_su);
    end
    checks++;
    if (su_sl_idx != 4) begin
      errors++;
      $display("FAIL small_up_align got shift_left index %0d exp 4", su_sl_idx);
    end
    checks++;
    if (first_bf_edge - last_acc_edge != 1) begin
      errors++;
      $display("FAIL small_full_latency got %0d exp 1", first_bf_edge - last_acc_edge);
    end
  endtask

  task automatic test_start_conv_same_cycle();
    sel = 1'b1;
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (o_ready !== 1'b0 || o_bf !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_idle got ready %b full %b exp 0 0", o_ready, o_bf);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_restart got ready %b exp 1", o_ready);
    end
    for (int unsigned i = 0; i < 6; i++) drive_cycle(1'b1, PW'(10 + i), 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_controls();
    sel = 1'b1;
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (o_bf !== 1'b1 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_in_full got full %b ready %b exp 1 0", o_bf, o_ready);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b1, 9'd21, 1'b0, 1'b0);
    drive_cycle(1'b1, 9'd22, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (o_col !== 5'd2 || o_row !== 5'd0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ignores got col %0d row %0d ready %b exp 2 0 1", o_col, o_row, o_ready);
    end
    for (int unsigned i = 0; i < 4; i++) drive_cycle(1'b1, PW'(23 + i), 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_full_frame_gaps();
    int unsigned budget;
    sel = 1'b0;
    clear_stats();
    budget = 0;
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    while (n_acc < 784 && budget < 5000) begin
      drive_cycle(($urandom_range(0, 3) != 0), PW'($urandom), 1'b0, 1'b0);
      budget++;
    end
    checks++;
    if (n_acc != 784) begin
      errors++;
      $display("FAIL frame_timeout got accepts %0d exp 784", n_acc);
    end
    repeat (2) drive_cycle(1'b1, PW'($urandom), 1'b0, 1'b0);
    checks++;
    if (n_sl != 784 || n_su != 27) begin
      errors++;
      $display("FAIL frame_totals got sl %0d su %0d exp sl 784 su 27", n_sl, n_su);
    end
  endtask

  task automatic test_full_hold();
    int sl_before;
    sel = 1'b0;
    sl_before = n_sl;
    for (int unsigned i = 0; i < 50; i++) drive_cycle(1'b1, PW'($urandom), 1'b0, 1'b0);
    checks++;
    if (n_sl != sl_before || o_bf !== 1'b1) begin
      errors++;
      $display("FAIL hold_full got extra sl %0d full %b exp 0 1", n_sl - sl_before, o_bf);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (o_bf !== 1'b0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL conv_release got full %b ready %b exp 0 0", o_bf, o_ready);
    end
  endtask

  task automatic test_reset_mid_row();
    sel = 1'b0;
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 153; i++) drive_cycle(1'b1, PW'(i + 1), 1'b0, 1'b0);
    checks++;
    if (o_col !== 5'd13 || o_row !== 5'd5) begin
      errors++;
      $display("FAIL mid_row_pos got col %0d row %0d exp 13 5", o_col, o_row);
    end
    pv_d = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({b_ready, b_sl, b_su, b_bf, b_win, b_col, b_row} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {b_ready, b_sl, b_su, b_bf, b_win, b_col, b_row});
    end
    pv_d = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    repeat (5) drive_cycle(1'b1, 9'h1AA, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 30; i++) drive_cycle(1'b1, PW'(i), 1'b0, 1'b0);
    checks++;
    if (o_col !== 5'd2 || o_row !== 5'd1) begin
      errors++;
      $display("FAIL post_reset_count got col %0d row %0d exp 2 1", o_col, o_row);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    test_reset();
    test_small_frame();
    test_start_conv_same_cycle();
    test_ignored_controls();
    test_full_frame_gaps();
    test_full_hold();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
